// File: rtl/mem_mp_if.sv
// mem_mp_if: read/write bus of the multi-read-port memory.
// Read data uses the same packing as raddr: port i at [i][31:0].
interface mem_mp_if #(
   parameter int NUM_RD = 2
);
   logic [NUM_RD-1:0]        ren;
   logic [NUM_RD-1:0][31:0]  raddr;
   logic [NUM_RD-1:0][31:0]  rdata;
   logic [NUM_RD-1:0]        rvalid;
   logic                     wen;
   logic [3:0]               wbe;
   logic [31:0]              waddr;
   logic [31:0]              wdata;

   modport master (output ren, raddr, wen, wbe, waddr, wdata,
                   input  rdata, rvalid);
   modport slave  (input  ren, raddr, wen, wbe, waddr, wdata,
                   output rdata, rvalid);
endinterface

// File: rtl/mem_mp.sv
// mem_mp: word memory with NUM_RD independent read ports and one byte-enabled write port.
// Define MEM_MP_WR_FWD_EN for write-first collisions; default is read-first.

module mem_mp_rd_lane #(
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ren,
   input  logic [31:0] word,
   output logic        rvalid,
   output logic [31:0] rdata
);
   logic [RD_LAT:1]       vld_pipe;
   logic [RD_LAT:1][31:0] dat_pipe;

   // Data stages load only with a valid beat so rdata holds between returns.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
         dat_pipe <= '0;
      end else begin
         vld_pipe[1] <= ren;
         if (ren) dat_pipe[1] <= word;
         for (int s = 2; s <= RD_LAT; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
         end
      end
   end

   assign rvalid = vld_pipe[RD_LAT];
   assign rdata  = dat_pipe[RD_LAT];
endmodule

module mem_mp #(
   parameter int NUM_RD     = 2,
   parameter int DEPTH_LOG2 = 14,
   parameter int RD_LAT     = 1
) (
   input logic     clk,
   input logic     reset,
   mem_mp_if.slave bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [31:0]             mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   widx;
   logic                    wr_go;
   logic [NUM_RD-1:0][31:0] word_all;
   logic [NUM_RD-1:0][31:0] rdata_w;
   logic [NUM_RD-1:0]       rvalid_w;
   logic [NUM_RD-1:0]       ren_w;
   logic                    unused_waddr_bits;

   assign widx  = bus.waddr[DEPTH_LOG2+1:2];
   assign wr_go = bus.wen & ~reset;
   assign ren_w = bus.ren;
   assign unused_waddr_bits = ^{bus.waddr[31:DEPTH_LOG2+2], bus.waddr[1:0]};

   always_ff @(posedge clk) begin
      if (wr_go) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.wbe[b]) mem[widx][8*b +: 8] <= bus.wdata[8*b +: 8];
         end
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [DEPTH_LOG2-1:0] ridx;
      logic [31:0]           old_w;
      logic                  unused_raddr_bits;

      assign ridx  = bus.raddr[i][DEPTH_LOG2+1:2];
      assign old_w = mem[ridx];
      assign unused_raddr_bits = ^{bus.raddr[i][31:DEPTH_LOG2+2], bus.raddr[i][1:0]};

`ifdef MEM_MP_WR_FWD_EN
      // Colliding read sees the merged word the write is about to store.
      always_comb begin
         word_all[i] = old_w;
         if (wr_go && widx == ridx) begin
            for (int b = 0; b < 4; b++) begin
               if (bus.wbe[b]) word_all[i][8*b +: 8] = bus.wdata[8*b +: 8];
            end
         end
      end
`else
      assign word_all[i] = old_w;
`endif
   end

   mem_mp_rd_lane #(.RD_LAT(RD_LAT)) u_lane [NUM_RD-1:0] (
      .clk    (clk),
      .reset  (reset),
      .ren    (ren_w),
      .word   (word_all),
      .rvalid (rvalid_w),
      .rdata  (rdata_w)
   );

   assign bus.rdata  = rdata_w;
   assign bus.rvalid = rvalid_w;
endmodule

// File: doc/mem_mp.md
MEM_MP -- requirements
Module: mem_mp

Interface
REQ-001 SHALL have parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-002 SHALL have parameter DEPTH_LOG2, default 14, log2 of word count.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles (1 or 2).
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ren  input  NUM_RD  per-port read request.
REQ-007 SHALL have port raddr  input  NUM_RD*32  packed byte addresses; port i at bits [32i+31:32i].
REQ-008 SHALL have port rdata  output  NUM_RD*32  packed read data, same packing as raddr.
REQ-009 SHALL have port rvalid  output  NUM_RD  per-port read-data-valid.
REQ-010 SHALL have port wen  input  1  write request.
REQ-011 SHALL have port wbe  input  4  write byte enables; bit b covers wdata[8b+7:8b].
REQ-012 SHALL have port waddr  input  32  write byte address.
REQ-013 SHALL have port wdata  input  32  write data.

Function
REQ-014 SHALL store 2^DEPTH_LOG2 32-bit words; word index = addr[DEPTH_LOG2+1:2]; addr[1:0] and bits above DEPTH_LOG2+1 ignored (aliasing wrap-around).
REQ-015 SHALL, on a rising edge with wen=1 and reset=0, update only the bytes whose wbe bit is 1; wbe=0000 with wen=1 is a no-op.
REQ-016 SHALL, for each port i with ren[i]=1 at edge N, present the addressed word on rdata port i with rvalid[i]=1 after edge N+RD_LAT-1 (RD_LAT=1: visible after edge N; RD_LAT=2: after edge N+1).
REQ-017 SHALL, for RD_LAT=2, pipeline one request per port per cycle with no bubbles; back-to-back requests yield back-to-back rvalid.
REQ-018 SHALL hold rdata of port i at its last returned value while rvalid[i]=0 (no spurious update).
REQ-019 SHALL serve all NUM_RD ports in the same cycle, including identical addresses, with no arbitration or stall.
REQ-020 SHALL treat read ports independently; ren on one port never affects another port's rvalid or rdata.
REQ-021 SHALL resolve same-cycle write and read of the same word per the Configuration section; reads of other words are unaffected by the write.

Reset
REQ-022 SHALL, while reset=1 at an edge, clear all rvalid and rdata to 0 and all read-pipeline stages to invalid.
REQ-023 SHALL ignore wen while reset=1; array contents are not cleared by reset.
REQ-024 SHALL drop reads in flight when reset asserts mid-operation; no rvalid for them after reset deasserts.
REQ-025 SHALL accept a new read on the first edge with reset=0; its rvalid timing matches REQ-016.

Configuration
REQ-026 SHALL use macro MEM_MP_WR_FWD_EN to select collision behaviour.
REQ-027 SHALL, with MEM_MP_WR_FWD_EN defined, return on a same-cycle same-word read the merged word: bytes with wbe=1 from wdata, other bytes from the old array value (write-first).
REQ-028 SHALL, without MEM_MP_WR_FWD_EN, return the pre-write array word on a same-cycle same-word read (read-first); the new value is visible to reads issued the following cycle.

Verification
REQ-029 SHALL cover: RD_LAT=1, write 0xDEADBEEF to 0x40 wbe=1111, next cycle ren0 at 0x40 -> rdata0=0xDEADBEEF, rvalid0=1 one edge later.
REQ-030 SHALL cover: word 0x40=0xDEADBEEF, write 0x000000AA wbe=0001 -> subsequent read 0x40 = 0xDEADBEAA; read of 0x42 returns same word.
REQ-031 SHALL cover: same cycle wen to 0x80 data 0x11223344 wbe=1111 (old 0) and ren1 at 0x80 -> rdata1=0x11223344 with MEM_MP_WR_FWD_EN, 0x00000000 without.
REQ-032 SHALL cover: RD_LAT=2, NUM_RD=3, ren=111 for 4 consecutive cycles at distinct addresses -> rvalid=111 for exactly 4 consecutive cycles, data in issue order, first after second edge.
REQ-033 SHALL cover: RD_LAT=2, ren0 issued, reset pulsed next cycle with wen=1 -> rvalid0 never asserts for that read, rdata0=0, write target unchanged.
REQ-034 SHALL cover: DEPTH_LOG2=4, write 0x5 to 0x0 then read 0x40 -> rdata=0x5 (address wrap).
